swire_multi_ctrl: RTL and testbench
===================================

SWIRE_MULTI_CTRL -- requirements
Module: swire_multi_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of captured DCS registers, range 1..8.
REQ-002 Parameter REG_IDS, default {8'hB5,8'hB1}: NUM_CH*8-bit packed DCS register IDs; channel i uses bits [8i+7:8i].
REQ-003 Parameter START_DELAY, default 24'hFFFFF0: clkrx cycles after reset before the first pulse train.
REQ-004 Parameters T_LOW, T_HIGH, T_GAP, defaults 38, 38, 1900: clkrx cycles for pulse low, pulse high and inter-frame gap; each >= 1.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 clkrx  input  1: sole clock; all logic on the rising edge.
REQ-007 rx_cmd  input  24: DSI packet header; [5:0] is the data type.
REQ-008 rx_cmd_valid  input  1: rx_cmd qualifier, one cycle per header.
REQ-009 rx_payload  input  32: payload word; [7:0] is the first byte.
REQ-010 rx_payload_valid  input  1: rx_payload qualifier.
REQ-011 rx_payload_valid_last  input  1: last payload word of the packet.
REQ-012 swire  output  1: single-wire pulse output, idle high.
REQ-013 busy  output  1: high while the encoder is outside IDLE and START_WAIT.
REQ-014 ch_pending  output  NUM_CH: per-channel flag, captured value not yet transmitted.
REQ-015 overwrite  output  1: one-cycle pulse when a capture replaces a still-pending value.

Function
REQ-016 All rx_* inputs SHALL be registered once; decode SHALL operate on the registered copies only.
REQ-017 A header SHALL arm capture when rx_cmd_valid is high and data type is 6'h39 or 6'h29.
REQ-018 Capture SHALL be disarmed on the first registered payload word, so only the first word of a packet is inspected.
REQ-019 Capture SHALL be disarmed by any non-matching header.
REQ-020 On the first word, if payload[7:0] == REG_IDS channel i, the block SHALL store payload[15:8] into value[i] and set ch_pending[i].
REQ-021 On a capture with ch_pending[i] already set, the new value SHALL overwrite the old one and overwrite SHALL pulse.
REQ-022 Duplicate REG_IDS SHALL resolve to the lowest matching channel index.
REQ-023 The encoder FSM SHALL have states START_WAIT, IDLE, LOAD, LOW, HIGH and GAP.
REQ-024 START_WAIT: a 24-bit counter SHALL run START_DELAY cycles, then the FSM SHALL go to IDLE; swire SHALL be high.
REQ-025 IDLE: when any ch_pending bit is set, the FSM SHALL select the lowest pending index and go to LOAD.
REQ-026 LOAD (1 cycle): the FSM SHALL copy value[sel] into an 8-bit pulse counter and clear ch_pending[sel].
REQ-027 LOAD: a capture to sel in that same cycle SHALL win, leaving ch_pending[sel] set for a later frame.
REQ-028 LOAD exit: if the count is 0 the FSM SHALL go to GAP; otherwise it SHALL go to LOW.
REQ-029 LOW: swire SHALL be 0 for exactly T_LOW cycles, then the FSM SHALL go to HIGH.
REQ-030 HIGH: swire SHALL be 1 for T_HIGH cycles and the counter SHALL decrement; the FSM SHALL go to LOW if the count is nonzero, else to GAP.
REQ-031 GAP: swire SHALL be 1 for T_GAP cycles, then the FSM SHALL go to IDLE.
REQ-032 Captures in any encoder state SHALL be accepted, and SHALL never modify the frame in progress.
REQ-033 swire SHALL be a registered output with no combinational path from inputs.

Reset
REQ-034 On rst_n low the block SHALL force swire=1, busy=0, ch_pending=0, overwrite=0, all values=0 and disarm capture.
REQ-035 On rst_n low the FSM SHALL go to START_WAIT with its counter cleared.
REQ-036 Reset mid-frame SHALL abort the frame, with swire high on the cycle after rst_n assertion is sampled.

Verification (START_DELAY=16, T_LOW=2, T_HIGH=2, T_GAP=8, defaults otherwise)
REQ-037 Reset release, no traffic -> swire high throughout, busy=0, ch_pending=0 after 100 cycles.
REQ-038 Header DT 0x39, then word 0x0000_03B1 -> ch_pending=2'b01; after START_DELAY, 3 low pulses of 2 cycles on swire, 8-cycle gap, ch_pending=0.
REQ-039 Word 0x0005_02B5 during START_WAIT, then 0x0004_01B1 -> channel 0 (1 pulse) sent before channel 1 (2 pulses), each frame followed by its gap.
REQ-040 Two B1 captures (values 4 then 6) before the encoder reaches LOAD -> overwrite pulses once, and exactly 6 pulses are sent.
REQ-041 Header DT 0x15, or B1 in the second payload word -> no capture, ch_pending stays 0.
REQ-042 rst_n asserted during the 2nd LOW of a 5-pulse frame -> swire=1 next cycle; after release no pulses until START_DELAY expires, and ch_pending=0.

Source files
------------

// File: rtl/swire_multi_ctrl.sv
// Captures selected DCS register writes from a DSI packet stream and replays each
// captured byte as a train of low pulses on a single-wire output, lowest channel first.
module swire_multi_ctrl #(
   parameter int                  NUM_CH      = 2,
   parameter logic [NUM_CH*8-1:0] REG_IDS     = {8'hB5, 8'hB1},
   parameter logic [23:0]         START_DELAY = 24'hFFFFF0,
   parameter int                  T_LOW       = 38,
   parameter int                  T_HIGH      = 38,
   parameter int                  T_GAP       = 1900
) (
   input  logic              clkrx,
   input  logic              rst_n,
   input  logic [23:0]       rx_cmd,
   input  logic              rx_cmd_valid,
   input  logic [31:0]       rx_payload,
   input  logic              rx_payload_valid,
   input  logic              rx_payload_valid_last,
   output logic              swire,
   output logic              busy,
   output logic [NUM_CH-1:0] ch_pending,
   output logic              overwrite
);

   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [23:0] START_LAST = (START_DELAY == 24'd0) ? 24'd0 : START_DELAY - 24'd1;
   localparam logic [23:0] LOW_LAST   = 24'(T_LOW - 1);
   localparam logic [23:0] HIGH_LAST  = 24'(T_HIGH - 1);
   localparam logic [23:0] GAP_LAST   = 24'(T_GAP - 1);

   typedef enum logic [2:0] {
      ST_START_WAIT,
      ST_IDLE,
      ST_LOAD,
      ST_LOW,
      ST_HIGH,
      ST_GAP
   } state_t;

   logic [23:0]       cmd_reg;
   logic              cmd_valid_reg;
   logic [31:0]       pay_reg;
   logic              pay_valid_reg;
   logic              pay_last_reg;

   logic              arm_reg;
   logic              dt_match;
   logic [NUM_CH-1:0] id_match;
   logic              cap_hit;
   logic [SEL_W-1:0]  cap_sel;
   logic [NUM_CH-1:0] cap_ch;
   logic [NUM_CH-1:0] clr_ch;
   logic [NUM_CH-1:0] ovw_ch;
   logic [NUM_CH-1:0] pend_next;
   logic [NUM_CH-1:0] ch_pending_reg;
   logic              overwrite_reg;
   logic [7:0]        value_reg [NUM_CH];

   state_t            state_reg, state_next;
   logic [23:0]       timer_reg, timer_next;
   logic [7:0]        cnt_reg, cnt_next;
   logic [SEL_W-1:0]  sel_reg, sel_next;
   logic              swire_reg, swire_next;
   logic              pend_any;
   logic [SEL_W-1:0]  pend_sel;

   // Header bits above the data type, the upper payload bytes and the last flag are carried but not decoded.
   logic unused_rx;
   assign unused_rx = ^{cmd_reg[23:6], pay_reg[31:16], pay_last_reg};

   always_ff @(posedge clkrx or negedge rst_n) begin
      if (!rst_n) begin
         cmd_reg       <= '0;
         cmd_valid_reg <= 1'b0;
         pay_reg       <= '0;
         pay_valid_reg <= 1'b0;
         pay_last_reg  <= 1'b0;
      end else begin
         cmd_reg       <= rx_cmd;
         cmd_valid_reg <= rx_cmd_valid;
         pay_reg       <= rx_payload;
         pay_valid_reg <= rx_payload_valid;
         pay_last_reg  <= rx_payload_valid_last;
      end
   end

   assign dt_match = (cmd_reg[5:0] == 6'h39) || (cmd_reg[5:0] == 6'h29);
   assign cap_hit  = arm_reg && pay_valid_reg && (|id_match);
   assign pend_any = |ch_pending_reg;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign id_match[gi]  = (pay_reg[7:0] == REG_IDS[8*gi +: 8]);
      assign cap_ch[gi]    = cap_hit && (cap_sel == SEL_W'(gi));
      assign clr_ch[gi]    = (state_reg == ST_LOAD) && (sel_reg == SEL_W'(gi));
      // A capture landing on the channel being loaded keeps it pending for a later frame.
      assign pend_next[gi] = cap_ch[gi] || (ch_pending_reg[gi] && !clr_ch[gi]);
      assign ovw_ch[gi]    = cap_ch[gi] && ch_pending_reg[gi] && !clr_ch[gi];
   end

   always_comb begin
      cap_sel  = '0;
      pend_sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (id_match[i]) cap_sel = SEL_W'(i);
         if (ch_pending_reg[i]) pend_sel = SEL_W'(i);
      end
   end

   always_ff @(posedge clkrx or negedge rst_n) begin
      if (!rst_n) begin
         arm_reg        <= 1'b0;
         ch_pending_reg <= '0;
         overwrite_reg  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) value_reg[i] <= '0;
      end else begin
         if (cmd_valid_reg) arm_reg <= dt_match;
         else if (pay_valid_reg) arm_reg <= 1'b0;
         ch_pending_reg <= pend_next;
         overwrite_reg  <= |ovw_ch;
         for (int i = 0; i < NUM_CH; i++) begin
            if (cap_ch[i]) value_reg[i] <= pay_reg[15:8];
         end
      end
   end

   always_ff @(posedge clkrx or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_START_WAIT;
         timer_reg <= '0;
         cnt_reg   <= '0;
         sel_reg   <= '0;
         swire_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         cnt_reg   <= cnt_next;
         sel_reg   <= sel_next;
         swire_reg <= swire_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg + 24'd1;
      cnt_next   = cnt_reg;
      sel_next   = sel_reg;
      case (state_reg)
         ST_START_WAIT: begin
            if (timer_reg == START_LAST) begin
               state_next = ST_IDLE;
               timer_next = '0;
            end
         end
         ST_IDLE: begin
            timer_next = '0;
            if (pend_any) begin
               state_next = ST_LOAD;
               sel_next   = pend_sel;
            end
         end
         ST_LOAD: begin
            timer_next = '0;
            cnt_next   = value_reg[sel_reg];
            state_next = (value_reg[sel_reg] == 8'd0) ? ST_GAP : ST_LOW;
         end
         ST_LOW: begin
            if (timer_reg == LOW_LAST) begin
               state_next = ST_HIGH;
               timer_next = '0;
            end
         end
         ST_HIGH: begin
            if (timer_reg == HIGH_LAST) begin
               timer_next = '0;
               cnt_next   = cnt_reg - 8'd1;
               state_next = (cnt_reg == 8'd1) ? ST_GAP : ST_LOW;
            end
         end
         ST_GAP: begin
            if (timer_reg == GAP_LAST) begin
               state_next = ST_IDLE;
               timer_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            timer_next = '0;
         end
      endcase
   end

   // swire is registered from the next state so it lines up with the state it belongs to.
   always_comb begin
      swire_next = (state_next != ST_LOW);
      busy       = (state_reg != ST_START_WAIT) && (state_reg != ST_IDLE);
   end

   assign swire      = swire_reg;
   assign ch_pending = ch_pending_reg;
   assign overwrite  = overwrite_reg;

endmodule

// File: tb/tb_swire_multi_ctrl.sv
// Bench for swire_multi_ctrl: directed scenarios then random traffic, every cycle
// compared against a timeline model of captures and pulse frames.
module tb_swire_multi_ctrl;

   localparam int NUM_CH = 2;
   localparam int SD     = 16;
   localparam int TL     = 2;
   localparam int TH     = 2;
   localparam int TG     = 8;
   localparam int P      = TL + TH;
   localparam int BIG    = 1 << 30;
   localparam logic [7:0] ID_TAB [NUM_CH] = '{8'hB1, 8'hB5};

   logic              clkrx = 1'b0;
   logic              rst_n = 1'b1;
   logic [23:0]       rx_cmd = '0;
   logic              rx_cmd_valid = 1'b0;
   logic [31:0]       rx_payload = '0;
   logic              rx_payload_valid = 1'b0;
   logic              rx_payload_valid_last = 1'b0;
   logic              swire;
   logic              busy;
   logic [NUM_CH-1:0] ch_pending;
   logic              overwrite;

   always #5 clkrx = ~clkrx;

   swire_multi_ctrl #(
      .START_DELAY (24'd16),
      .T_LOW       (TL),
      .T_HIGH      (TH),
      .T_GAP       (TG)
   ) dut (
      .clkrx                 (clkrx),
      .rst_n                 (rst_n),
      .rx_cmd                (rx_cmd),
      .rx_cmd_valid          (rx_cmd_valid),
      .rx_payload            (rx_payload),
      .rx_payload_valid      (rx_payload_valid),
      .rx_payload_valid_last (rx_payload_valid_last),
      .swire                 (swire),
      .busy                  (busy),
      .ch_pending            (ch_pending),
      .overwrite             (overwrite)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int falls    = 0;
   int ovw_cnt  = 0;
   logic prev_sw = 1'b1;

   // Model: cycle index since reset, scheduled LOAD, and the current frame's start/length/end.
   int m_k, m_free, m_load, m_sel, m_fL, m_fn, m_fend;
   bit m_fv, m_arm, m_ovw;
   logic [NUM_CH-1:0] m_pend;
   logic [7:0] m_val [NUM_CH];
   bit d_cmd_v, d_pay_v;
   logic [5:0] d_dt;
   logic [15:0] d_pay;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, m_k);
      end
   endtask

   task automatic model_reset();
      m_k = 0; m_free = SD; m_load = -1; m_sel = 0;
      m_fv = 0; m_fL = 0; m_fn = 0; m_fend = 0;
      m_arm = 0; m_ovw = 0; m_pend = '0;
      for (int i = 0; i < NUM_CH; i++) m_val[i] = '0;
      d_cmd_v = 0; d_pay_v = 0; d_dt = '0; d_pay = '0;
   endtask

   task automatic model_edge();
      logic [NUM_CH-1:0] pend_old;
      logic [7:0] val_old [NUM_CH];
      int clr, hit, n;
      if (!rst_n) begin
         model_reset();
         return;
      end
      pend_old = m_pend;
      val_old  = m_val;
      clr = -1;
      hit = -1;
      if (m_load == m_k) begin
         n = int'(val_old[m_sel]);
         m_fv = 1; m_fL = m_k; m_fn = n;
         m_fend = m_k + 1 + n * P + TG;
         m_free = m_fend;
         clr = m_sel;
         m_load = -1;
      end else if (m_k >= m_free && pend_old != '0) begin
         for (int i = NUM_CH - 1; i >= 0; i--) if (pend_old[i]) m_sel = i;
         m_load = m_k + 1;
         m_free = BIG;
      end
      if (d_pay_v && m_arm)
         for (int i = NUM_CH - 1; i >= 0; i--) if (d_pay[7:0] == ID_TAB[i]) hit = i;
      m_ovw = 0;
      if (clr >= 0) m_pend[clr] = 1'b0;
      if (hit >= 0) begin
         m_ovw = pend_old[hit] && (hit != clr);
         m_pend[hit] = 1'b1;
         m_val[hit] = d_pay[15:8];
      end
      if (d_cmd_v) m_arm = (d_dt == 6'h39) || (d_dt == 6'h29);
      else if (d_pay_v) m_arm = 0;
      d_cmd_v = rx_cmd_valid;
      d_dt    = rx_cmd[5:0];
      d_pay_v = rx_payload_valid;
      d_pay   = rx_payload[15:0];
      m_k++;
   endtask

   task automatic check_outputs();
      int s;
      bit exp_low, exp_busy;
      s = m_k;
      exp_low  = m_fv && (s > m_fL) && ((s - m_fL - 1) < m_fn * P) && (((s - m_fL - 1) % P) < TL);
      exp_busy = (s == m_load) || (m_fv && s >= m_fL && s < m_fend);
      chk("swire", swire, !exp_low);
      chk("busy", busy, exp_busy);
      chk("ch_pending", ch_pending, m_pend);
      chk("overwrite", overwrite, m_ovw);
      if (prev_sw === 1'b1 && swire === 1'b0) falls++;
      if (overwrite === 1'b1) ovw_cnt++;
      prev_sw = swire;
   endtask

   task automatic tick();
      @(posedge clkrx);
      model_edge();
      @(negedge clkrx);
      check_outputs();
   endtask

   task automatic send_hdr(input logic [5:0] dt);
      rx_cmd = {18'($urandom), dt};
      rx_cmd_valid = 1'b1;
      tick();
      rx_cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      rx_payload = w;
      rx_payload_valid = 1'b1;
      rx_payload_valid_last = last;
      tick();
      rx_payload_valid = 1'b0;
      rx_payload_valid_last = 1'b0;
   endtask

   task automatic do_reset();
      rx_cmd_valid = 1'b0;
      rx_payload_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("swire_at_reset", swire, 1'b1);
      chk("busy_at_reset", busy, 1'b0);
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int r;
      #2;
      // Reset release with no traffic
      do_reset();
      falls = 0;
      repeat (100) tick();
      chk("idle_pulses", falls, 0);

      // Single B1 capture of value 3
      falls = 0;
      send_hdr(6'h39);
      send_word(32'h0000_03B1, 1'b1);
      tick();
      chk("b1_pending", ch_pending, 2'b01);
      repeat (40) tick();
      chk("b1_pulses", falls, 3);
      chk("b1_cleared", ch_pending, 2'b00);

      // Two channels captured during START_WAIT
      do_reset();
      falls = 0;
      send_hdr(6'h39);
      send_word(32'h0005_02B5, 1'b1);
      send_hdr(6'h29);
      send_word(32'h0004_01B1, 1'b1);
      repeat (70) tick();
      chk("two_ch_pulses", falls, 3);

      // Overwrite before the encoder loads
      do_reset();
      falls = 0;
      ovw_cnt = 0;
      send_hdr(6'h39);
      send_word(32'h0000_04B1, 1'b1);
      send_hdr(6'h39);
      send_word(32'h0000_06B1, 1'b1);
      repeat (70) tick();
      chk("overwrite_count", ovw_cnt, 1);
      chk("overwrite_pulses", falls, 6);

      // Wrong data type, and B1 only in the second word
      falls = 0;
      send_hdr(6'h15);
      send_word(32'h0000_07B1, 1'b1);
      send_hdr(6'h39);
      send_word(32'h0000_0022, 1'b0);
      send_word(32'h0000_07B1, 1'b1);
      repeat (10) tick();
      chk("no_capture_pending", ch_pending, 2'b00);
      chk("no_capture_pulses", falls, 0);

      // Reset during the second LOW of a 5-pulse frame
      send_hdr(6'h39);
      send_word(32'h0000_05B1, 1'b1);
      falls = 0;
      for (int i = 0; i < 60 && falls < 2; i++) tick();
      chk("second_low_reached", 32'(falls == 2), 1);
      chk("swire_in_low", swire, 1'b0);
      do_reset();
      falls = 0;
      repeat (15) tick();
      chk("no_pulse_start_wait", falls, 0);
      repeat (40) tick();
      chk("no_pulse_after_reset", falls, 0);
      chk("pending_after_reset", ch_pending, 2'b00);

      // Random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         r = int'($urandom_range(0, 29));
         rx_cmd_valid = (r < 3);
         case ($urandom_range(0, 3))
            0:       rx_cmd = {18'($urandom), 6'h39};
            1:       rx_cmd = {18'($urandom), 6'h29};
            2:       rx_cmd = {18'($urandom), 6'h15};
            default: rx_cmd = 24'($urandom);
         endcase
         rx_payload_valid = (r >= 3 && r < 7);
         case ($urandom_range(0, 2))
            0:       rx_payload = {16'($urandom), 8'($urandom_range(0, 6)), 8'hB1};
            1:       rx_payload = {16'($urandom), 8'($urandom_range(0, 6)), 8'hB5};
            default: rx_payload = {16'($urandom), 8'($urandom_range(0, 6)), 8'($urandom)};
         endcase
         rx_payload_valid_last = 1'($urandom);
         tick();
      end
      rx_cmd_valid = 1'b0;
      rx_payload_valid = 1'b0;
      repeat (80) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
